// File: rtl/id_stage_hazard_pipe.sv
// Decode-stage back end: operand resolution, RAW hazard detection, early
// branch resolution and the ID/EX pipeline register with a valid/ready handshake.
module id_stage_hazard_pipe #(
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned REG_WIDTH       = 32,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned CTRL_WIDTH      = 12,
  parameter bit          FWD_EN          = 1'b1,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       id_valid,
  output logic                       id_ready,
  input  logic [PC_WIDTH-1:0]        id_pc,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rd,
  input  logic                       id_use_rs1,
  input  logic                       id_use_rs2,
  input  logic                       id_reg_wr_en,
  input  logic                       id_is_load,
  input  logic                       id_is_branch,
  input  logic [2:0]                 id_funct3,
  input  logic [REG_WIDTH-1:0]       id_imm,
  input  logic [CTRL_WIDTH-1:0]      id_ctrl,
  input  logic [REG_WIDTH-1:0]       rf_rs1_data,
  input  logic [REG_WIDTH-1:0]       rf_rs2_data,
  input  logic                       ex_mem_valid,
  input  logic                       ex_mem_reg_wr_en,
  input  logic                       ex_mem_is_load,
  input  logic [REG_ADDR_WIDTH-1:0]  ex_mem_rd,
  input  logic [REG_WIDTH-1:0]       ex_mem_alu_out,
  input  logic                       mem_wb_valid,
  input  logic                       mem_wb_reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]  mem_wb_rd,
  input  logic [REG_WIDTH-1:0]       mem_wb_data,
  input  logic                       ex_ready,
  output logic                       ex_valid,
  output logic [PC_WIDTH-1:0]        ex_pc,
  output logic [REG_WIDTH-1:0]       ex_rs1_data,
  output logic [REG_WIDTH-1:0]       ex_rs2_data,
  output logic [REG_WIDTH-1:0]       ex_imm,
  output logic [CTRL_WIDTH-1:0]      ex_ctrl,
  output logic [REG_ADDR_WIDTH-1:0]  ex_rd,
  output logic                       ex_reg_wr_en,
  output logic                       ex_is_load,
  output logic                       br_taken,
  output logic [PC_WIDTH-1:0]        br_target,
  output logic                       if_flush,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]       pc;
    logic [REG_WIDTH-1:0]      rs1_data;
    logic [REG_WIDTH-1:0]      rs2_data;
    logic [REG_WIDTH-1:0]      imm;
    logic [CTRL_WIDTH-1:0]     ctrl;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_wr_en;
    logic                      is_load;
  } idex_t;

  idex_t                      idex_d, idex_q;
  logic                       ex_valid_d, ex_valid_q;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;

  // A used, nonzero source that a valid writer is about to overwrite.
  function automatic logic src_match(
    input logic                      use_src,
    input logic [REG_ADDR_WIDTH-1:0] idx,
    input logic                      wr_valid,
    input logic                      wr_en,
    input logic [REG_ADDR_WIDTH-1:0] wr_rd
  );
    return use_src && (idx != '0) && wr_valid && wr_en && (wr_rd == idx);
  endfunction

  logic rs1_idex_c, rs2_idex_c, rs1_exmem_c, rs2_exmem_c, rs1_memwb_c, rs2_memwb_c;

  assign rs1_idex_c  = src_match(id_use_rs1, id_rs1, ex_valid_q, idex_q.reg_wr_en, idex_q.rd);
  assign rs2_idex_c  = src_match(id_use_rs2, id_rs2, ex_valid_q, idex_q.reg_wr_en, idex_q.rd);
  assign rs1_exmem_c = src_match(id_use_rs1, id_rs1, ex_mem_valid, ex_mem_reg_wr_en, ex_mem_rd);
  assign rs2_exmem_c = src_match(id_use_rs2, id_rs2, ex_mem_valid, ex_mem_reg_wr_en, ex_mem_rd);
  assign rs1_memwb_c = src_match(id_use_rs1, id_rs1, mem_wb_valid, mem_wb_reg_wr_en, mem_wb_rd);
  assign rs2_memwb_c = src_match(id_use_rs2, id_rs2, mem_wb_valid, mem_wb_reg_wr_en, mem_wb_rd);

  logic hazard_c;
  logic fire_c;
  logic idex_open_c;

  // Without forwarding, every in-flight writer blocks; with it, only an
  // ID/EX writer or a load still in EX/MEM can't supply its value in time.
  always_comb begin
    hazard_c = rs1_idex_c || rs2_idex_c;
    if (FWD_EN) begin
      hazard_c = hazard_c || (ex_mem_is_load && (rs1_exmem_c || rs2_exmem_c));
    end else begin
      hazard_c = hazard_c || rs1_exmem_c || rs2_exmem_c || rs1_memwb_c || rs2_memwb_c;
    end
  end

  assign idex_open_c = !ex_valid_q || ex_ready;
  assign id_ready    = !hazard_c && idex_open_c;
  assign fire_c      = id_valid && id_ready;

  logic [REG_WIDTH-1:0] op1_c, op2_c;

  always_comb begin
    op1_c = rf_rs1_data;
    op2_c = rf_rs2_data;
    if (FWD_EN) begin
      if (rs1_exmem_c && !ex_mem_is_load) op1_c = ex_mem_alu_out;
      else if (rs1_memwb_c)               op1_c = mem_wb_data;
      if (rs2_exmem_c && !ex_mem_is_load) op2_c = ex_mem_alu_out;
      else if (rs2_memwb_c)               op2_c = mem_wb_data;
    end
    if (id_rs1 == '0) op1_c = '0;
    if (id_rs2 == '0) op2_c = '0;
  end

  logic cond_c;

  always_comb begin
    cond_c = 1'b0;
    case (id_funct3)
      3'b000:  cond_c = (op1_c == op2_c);
      3'b001:  cond_c = (op1_c != op2_c);
      3'b100:  cond_c = ($signed(op1_c) <  $signed(op2_c));
      3'b101:  cond_c = ($signed(op1_c) >= $signed(op2_c));
      3'b110:  cond_c = (op1_c <  op2_c);
      3'b111:  cond_c = (op1_c >= op2_c);
      default: cond_c = 1'b0;
    endcase
  end

  assign br_taken  = fire_c && id_is_branch && cond_c;
  assign if_flush  = br_taken;
  assign br_target = id_pc + PC_WIDTH'($signed(id_imm));

  // ID/EX advances only when EX has drained it; a non-firing cycle leaves a bubble.
  always_comb begin
    idex_d      = idex_q;
    ex_valid_d  = ex_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (idex_open_c) begin
      ex_valid_d = fire_c;
      if (fire_c) begin
        idex_d.pc        = id_pc;
        idex_d.rs1_data  = op1_c;
        idex_d.rs2_data  = op2_c;
        idex_d.imm       = id_imm;
        idex_d.ctrl      = id_ctrl;
        idex_d.rd        = id_rd;
        idex_d.reg_wr_en = id_reg_wr_en;
        idex_d.is_load   = id_is_load;
      end
    end
    if (id_valid && hazard_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idex_q      <= '0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = idex_q.pc;
  assign ex_rs1_data  = idex_q.rs1_data;
  assign ex_rs2_data  = idex_q.rs2_data;
  assign ex_imm       = idex_q.imm;
  assign ex_ctrl      = idex_q.ctrl;
  assign ex_rd        = idex_q.rd;
  assign ex_reg_wr_en = idex_q.reg_wr_en;
  assign ex_is_load   = idex_q.is_load;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_hazard_pipe.sv
// Directed bench for id_stage_hazard_pipe: a forwarding instance (16-bit counter)
// and a non-forwarding instance with a 3-bit counter to reach saturation quickly.
module tb_id_stage_hazard_pipe;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 32;
  localparam int unsigned CW = 12;

  logic clk = 1'b0;
  logic reset_n;
  logic id_valid, id_use_rs1, id_use_rs2, id_reg_wr_en, id_is_load, id_is_branch;
  logic [PW-1:0] id_pc;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]    id_funct3;
  logic [DW-1:0] id_imm, rf_rs1_data, rf_rs2_data, ex_mem_alu_out, mem_wb_data;
  logic [CW-1:0] id_ctrl;
  logic ex_mem_valid, ex_mem_reg_wr_en, ex_mem_is_load, mem_wb_valid, mem_wb_reg_wr_en;
  logic [AW-1:0] ex_mem_rd, mem_wb_rd;
  logic ex_ready;

  logic id_ready, ex_valid, ex_reg_wr_en, ex_is_load, br_taken, if_flush;
  logic [PW-1:0] ex_pc, br_target;
  logic [DW-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [CW-1:0] ex_ctrl;
  logic [AW-1:0] ex_rd;
  logic [15:0]   stall_cnt;

  logic id_ready_n, ex_valid_n, ex_reg_wr_en_n, ex_is_load_n, br_taken_n, if_flush_n;
  logic [PW-1:0] ex_pc_n, br_target_n;
  logic [DW-1:0] ex_rs1_data_n, ex_rs2_data_n, ex_imm_n;
  logic [CW-1:0] ex_ctrl_n;
  logic [AW-1:0] ex_rd_n;
  logic [2:0]    stall_cnt_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_hazard_pipe #(.FWD_EN(1'b1), .STALL_CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
    .id_funct3(id_funct3), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .ex_mem_valid(ex_mem_valid), .ex_mem_reg_wr_en(ex_mem_reg_wr_en), .ex_mem_is_load(ex_mem_is_load),
    .ex_mem_rd(ex_mem_rd), .ex_mem_alu_out(ex_mem_alu_out),
    .mem_wb_valid(mem_wb_valid), .mem_wb_reg_wr_en(mem_wb_reg_wr_en), .mem_wb_rd(mem_wb_rd),
    .mem_wb_data(mem_wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_rd(ex_rd), .ex_reg_wr_en(ex_reg_wr_en), .ex_is_load(ex_is_load), .br_taken(br_taken),
    .br_target(br_target), .if_flush(if_flush), .stall_cnt(stall_cnt)
  );

  id_stage_hazard_pipe #(.FWD_EN(1'b0), .STALL_CNT_WIDTH(3)) dut_nf (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ready(id_ready_n), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
    .id_funct3(id_funct3), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .ex_mem_valid(ex_mem_valid), .ex_mem_reg_wr_en(ex_mem_reg_wr_en), .ex_mem_is_load(ex_mem_is_load),
    .ex_mem_rd(ex_mem_rd), .ex_mem_alu_out(ex_mem_alu_out),
    .mem_wb_valid(mem_wb_valid), .mem_wb_reg_wr_en(mem_wb_reg_wr_en), .mem_wb_rd(mem_wb_rd),
    .mem_wb_data(mem_wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid_n), .ex_pc(ex_pc_n),
    .ex_rs1_data(ex_rs1_data_n), .ex_rs2_data(ex_rs2_data_n), .ex_imm(ex_imm_n), .ex_ctrl(ex_ctrl_n),
    .ex_rd(ex_rd_n), .ex_reg_wr_en(ex_reg_wr_en_n), .ex_is_load(ex_is_load_n), .br_taken(br_taken_n),
    .br_target(br_target_n), .if_flush(if_flush_n), .stall_cnt(stall_cnt_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_reg_wr_en = 0; id_is_load = 0; id_is_branch = 0;
    id_funct3 = '0; id_imm = '0; id_ctrl = '0; rf_rs1_data = '0; rf_rs2_data = '0;
    ex_mem_valid = 0; ex_mem_reg_wr_en = 0; ex_mem_is_load = 0; ex_mem_rd = '0; ex_mem_alu_out = '0;
    mem_wb_valid = 0; mem_wb_reg_wr_en = 0; mem_wb_rd = '0; mem_wb_data = '0;
    ex_ready = 1;
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    set_idle();
    repeat (2) tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b exp 0", ex_valid); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
    checks++; if (ex_pc !== 32'd0) begin errors++; $display("FAIL reset_ex_pc: got %h exp 0", ex_pc); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready: got %b exp 1", id_ready); end
    reset_n = 1;
  endtask

  task automatic test_raw_stall();
    do_reset();
    id_valid = 1; id_rd = 5; id_reg_wr_en = 1; id_pc = 32'h40;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5) begin errors++; $display("FAIL raw_add_issued: got v=%b rd=%0d exp v=1 rd=5", ex_valid, ex_rd); end
    id_rs1 = 5; id_use_rs1 = 1; id_rd = 6; id_pc = 32'h44; rf_rs1_data = 32'hDEAD;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL raw_id_ready: got %b exp 0", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL raw_bubble: got %b exp 0", ex_valid); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL raw_stall_cnt: got %0d exp 1", stall_cnt); end
    ex_mem_valid = 1; ex_mem_reg_wr_en = 1; ex_mem_rd = 5; ex_mem_alu_out = 32'h1234;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got %b exp 1", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rs1_data !== 32'h1234) begin errors++; $display("FAIL raw_fwd_rs1: got v=%b d=%h exp v=1 d=00001234", ex_valid, ex_rs1_data); end
    checks++; if (ex_pc !== 32'h44 || stall_cnt !== 16'd1) begin errors++; $display("FAIL raw_pc_cnt: got pc=%h cnt=%0d exp pc=44 cnt=1", ex_pc, stall_cnt); end
    set_idle();
  endtask

  task automatic test_fwd_priority();
    do_reset();
    id_valid = 1; id_rs2 = 3; id_use_rs2 = 1; rf_rs2_data = 32'hC;
    ex_mem_valid = 1; ex_mem_reg_wr_en = 1; ex_mem_rd = 3; ex_mem_alu_out = 32'hA;
    mem_wb_valid = 1; mem_wb_reg_wr_en = 1; mem_wb_rd = 3; mem_wb_data = 32'hB;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL prio_ready: got %b exp 1", id_ready); end
    tick();
    checks++; if (ex_rs2_data !== 32'hA) begin errors++; $display("FAIL prio_exmem_wins: got %h exp a", ex_rs2_data); end
    ex_mem_valid = 0;
    tick();
    checks++; if (ex_rs2_data !== 32'hB) begin errors++; $display("FAIL prio_memwb: got %h exp b", ex_rs2_data); end
    mem_wb_valid = 0;
    tick();
    checks++; if (ex_rs2_data !== 32'hC) begin errors++; $display("FAIL prio_rf: got %h exp c", ex_rs2_data); end
    ex_mem_valid = 1; mem_wb_valid = 1; ex_mem_reg_wr_en = 0;
    tick();
    checks++; if (ex_rs2_data !== 32'hB) begin errors++; $display("FAIL prio_exmem_no_wr: got %h exp b", ex_rs2_data); end
    ex_mem_reg_wr_en = 1; ex_mem_is_load = 1;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL prio_load_use: got %b exp 0", id_ready); end
    set_idle();
  endtask

  task automatic test_no_fwd();
    do_reset();
    id_valid = 1; id_rs1 = 7; id_use_rs1 = 1; rf_rs1_data = 32'h55;
    mem_wb_valid = 1; mem_wb_reg_wr_en = 1; mem_wb_rd = 7; mem_wb_data = 32'h77;
    #1;
    checks++; if (id_ready_n !== 1'b0 || id_ready !== 1'b1) begin errors++; $display("FAIL nf_ready: got nf=%b fwd=%b exp nf=0 fwd=1", id_ready_n, id_ready); end
    tick();
    checks++; if (ex_valid_n !== 1'b0 || stall_cnt_n !== 3'd1) begin errors++; $display("FAIL nf_stall: got v=%b cnt=%0d exp v=0 cnt=1", ex_valid_n, stall_cnt_n); end
    checks++; if (ex_rs1_data !== 32'h77) begin errors++; $display("FAIL fwd_memwb_rs1: got %h exp 77", ex_rs1_data); end
    repeat (8) tick();
    checks++; if (stall_cnt_n !== 3'd7 || ex_valid_n !== 1'b0) begin errors++; $display("FAIL nf_saturate: got cnt=%0d v=%b exp cnt=7 v=0", stall_cnt_n, ex_valid_n); end
    mem_wb_valid = 0;
    #1;
    checks++; if (id_ready_n !== 1'b1) begin errors++; $display("FAIL nf_release: got %b exp 1", id_ready_n); end
    tick();
    checks++; if (ex_valid_n !== 1'b1 || ex_rs1_data_n !== 32'h55) begin errors++; $display("FAIL nf_rf_operand: got v=%b d=%h exp v=1 d=55", ex_valid_n, ex_rs1_data_n); end
    checks++; if (stall_cnt_n !== 3'd7) begin errors++; $display("FAIL nf_cnt_hold: got %0d exp 7", stall_cnt_n); end
    set_idle();
  endtask

  task automatic test_branch();
    do_reset();
    id_valid = 1; id_is_branch = 1; id_funct3 = 3'b100; id_rs1 = 1; id_rs2 = 2;
    id_use_rs1 = 1; id_use_rs2 = 1; rf_rs1_data = 32'hFFFF_FFFF; rf_rs2_data = 32'h1;
    id_pc = 32'h100; id_imm = 32'h20;
    ex_mem_valid = 1; ex_mem_reg_wr_en = 1; ex_mem_rd = 1; ex_mem_is_load = 1;
    #1;
    checks++; if (br_taken !== 1'b0 || id_ready !== 1'b0) begin errors++; $display("FAIL br_stalled: got taken=%b rdy=%b exp 0 0", br_taken, id_ready); end
    ex_mem_valid = 0;
    #1;
    checks++; if (br_taken !== 1'b1 || if_flush !== 1'b1 || br_target !== 32'h120) begin errors++; $display("FAIL br_blt: got t=%b f=%b tgt=%h exp 1 1 120", br_taken, if_flush, br_target); end
    id_funct3 = 3'b110; #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_bltu: got %b exp 0", br_taken); end
    id_funct3 = 3'b101; #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_bge: got %b exp 0", br_taken); end
    id_funct3 = 3'b111; #1;
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_bgeu: got %b exp 1", br_taken); end
    rf_rs1_data = 32'h5; rf_rs2_data = 32'h5; id_funct3 = 3'b000; #1;
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_beq: got %b exp 1", br_taken); end
    id_funct3 = 3'b001; #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_bne: got %b exp 0", br_taken); end
    id_funct3 = 3'b010; #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_illegal_f3: got %b exp 0", br_taken); end
    id_funct3 = 3'b000; id_valid = 0; #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_no_fire: got %b exp 0", br_taken); end
    id_valid = 1; id_funct3 = 3'b100; rf_rs1_data = 32'hFFFF_FFFF; rf_rs2_data = 32'h1; id_imm = 32'hFFFF_FFF0;
    #1;
    checks++; if (br_taken !== 1'b1 || br_target !== 32'hF0) begin errors++; $display("FAIL br_neg_imm: got t=%b tgt=%h exp 1 f0", br_taken, br_target); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_imm !== 32'hFFFF_FFF0) begin errors++; $display("FAIL br_enters_idex: got v=%b pc=%h imm=%h exp 1 100 fffffff0", ex_valid, ex_pc, ex_imm); end
    set_idle();
    #1;
    checks++; if (br_taken !== 1'b0 || if_flush !== 1'b0) begin errors++; $display("FAIL br_one_cycle: got t=%b f=%b exp 0 0", br_taken, if_flush); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    id_valid = 1; id_pc = 32'h300; id_ctrl = 12'hABC; id_rd = 4; id_reg_wr_en = 1; id_imm = 32'h11;
    tick();
    ex_ready = 0; id_pc = 32'h200; id_ctrl = 12'h123; id_rd = 0; id_reg_wr_en = 0; id_imm = 32'h22;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_id_ready[%0d]: got %b exp 0", i, id_ready); end
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h300 || ex_ctrl !== 12'hABC || ex_rd !== 5'd4 || ex_imm !== 32'h11)
        begin errors++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h ctrl=%h rd=%0d imm=%h exp 1 300 abc 4 11", i, ex_valid, ex_pc, ex_ctrl, ex_rd, ex_imm); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL bp_cnt[%0d]: got %0d exp 0", i, stall_cnt); end
    end
    ex_ready = 1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b exp 1", id_ready); end
    tick();
    checks++; if (ex_pc !== 32'h200 || ex_ctrl !== 12'h123) begin errors++; $display("FAIL bp_next: got pc=%h ctrl=%h exp 200 123", ex_pc, ex_ctrl); end
    ex_ready = 0; id_rs1 = 8; id_use_rs1 = 1;
    ex_mem_valid = 1; ex_mem_reg_wr_en = 1; ex_mem_rd = 8; ex_mem_is_load = 1;
    tick();
    checks++; if (stall_cnt !== 16'd1 || ex_pc !== 32'h200) begin errors++; $display("FAIL bp_plus_hazard: got cnt=%0d pc=%h exp 1 200", stall_cnt, ex_pc); end
    set_idle();
  endtask

  task automatic test_zero_reg_and_reset();
    do_reset();
    id_valid = 1; id_rd = 0; id_reg_wr_en = 1; id_pc = 32'h500;
    tick();
    id_rs1 = 0; id_use_rs1 = 1; rf_rs1_data = 32'hFFFF; id_rd = 9;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL x0_no_stall: got %b exp 1", id_ready); end
    tick();
    checks++; if (ex_rs1_data !== 32'd0 || ex_rd !== 5'd9) begin errors++; $display("FAIL x0_operand: got d=%h rd=%0d exp 0 9", ex_rs1_data, ex_rd); end
    id_rs1 = 9; id_rd = 0; id_reg_wr_en = 0;
    ex_mem_valid = 1; ex_mem_reg_wr_en = 1; ex_mem_rd = 9; ex_mem_is_load = 1;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL mid_stall_ready: got %b exp 0", id_ready); end
    repeat (2) tick();
    checks++; if (stall_cnt !== 16'd2 || ex_valid !== 1'b0) begin errors++; $display("FAIL mid_stall_cnt: got cnt=%0d v=%b exp 2 0", stall_cnt, ex_valid); end
    reset_n = 0;
    tick();
    checks++; if (ex_valid !== 1'b0 || stall_cnt !== 16'd0 || ex_rd !== 5'd0) begin errors++; $display("FAIL mid_stall_reset: got v=%b cnt=%0d rd=%0d exp 0 0 0", ex_valid, stall_cnt, ex_rd); end
    reset_n = 1;
    set_idle();
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_fwd_priority();
    test_no_fwd();
    test_branch();
    test_back_pressure();
    test_zero_reg_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_hazard_pipe.md
Name: id_stage_hazard_pipe

Overview:
- Parametrised decode-stage back end. Takes an already-decoded IF/ID instruction plus register-file read data.
- Resolves operands: forwards from EX/MEM and MEM/WB, or stalls when forwarding is disabled.
- Detects RAW hazards, resolves conditional branches in ID, and owns the ID/EX pipeline register with a valid/ready handshake toward EX.
- Sits between the register file / control logic and the EX stage.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- REG_WIDTH, 32, data width.
- PC_WIDTH, 32, PC width.
- CTRL_WIDTH, 12, opaque control bundle width, passed through to EX.
- FWD_EN, 1, 1 = forwarding from EX/MEM and MEM/WB; 0 = stall until the writer retires.
- STALL_CNT_WIDTH, 16, width of the hazard-stall performance counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- id_valid  in  1  IF/ID holds an instruction
- id_ready  out  1  ID accepts the instruction this cycle
- id_pc  in  PC_WIDTH  instruction PC
- id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  register indices
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_reg_wr_en  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_is_branch  in  1  conditional branch
- id_funct3  in  3  branch condition
- id_imm  in  REG_WIDTH  sign-extended immediate
- id_ctrl  in  CTRL_WIDTH  control bundle
- rf_rs1_data, rf_rs2_data  in  REG_WIDTH  register-file read data (no write-through)
- ex_mem_valid, ex_mem_reg_wr_en, ex_mem_is_load  in  1  EX/MEM writer info
- ex_mem_rd  in  REG_ADDR_WIDTH  EX/MEM destination
- ex_mem_alu_out  in  REG_WIDTH  EX/MEM ALU result
- mem_wb_valid, mem_wb_reg_wr_en  in  1  MEM/WB writer info
- mem_wb_rd  in  REG_ADDR_WIDTH  MEM/WB destination
- mem_wb_data  in  REG_WIDTH  write-back data
- ex_ready  in  1  EX accepts the ID/EX contents
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_pc  out  PC_WIDTH  registered PC
- ex_rs1_data, ex_rs2_data  out  REG_WIDTH  registered resolved operands
- ex_imm  out  REG_WIDTH  registered immediate
- ex_ctrl  out  CTRL_WIDTH  registered control bundle
- ex_rd  out  REG_ADDR_WIDTH  registered destination
- ex_reg_wr_en, ex_is_load  out  1  registered flags
- br_taken  out  1  branch taken (combinational, only on fire)
- br_target  out  PC_WIDTH  id_pc + id_imm, truncated to PC_WIDTH
- if_flush  out  1  equals br_taken
- stall_cnt  out  STALL_CNT_WIDTH  saturating hazard-stall count

Behaviour:
- **Reset:** reset_n low at a clk edge clears every registered output to 0 (ex_valid=0, stall_cnt=0). Reset mid-stall discards the ID/EX contents.
- **Source qualification:** a source matches a writer when all of the following hold: use bit=1, index!=0, writer valid, writer reg_wr_en=1, writer rd==index. Index 0 always resolves to operand 0 and never hazards.
- **Hazard, FWD_EN=1:** stall if any used source matches either
  - the ID/EX occupant (ex_valid, ex_reg_wr_en, ex_rd), or
  - EX/MEM with ex_mem_is_load=1.
- **Hazard, FWD_EN=0:** stall if any used source matches ID/EX, EX/MEM or MEM/WB.
- **Operand mux, FWD_EN=1:** priority EX/MEM (non-load) > MEM/WB > rf data.
- **Operand mux, FWD_EN=0:** rf data only.
- **Handshake:**
  - id_ready = !stall && (!ex_valid || ex_ready).
  - fire = id_valid && id_ready.
- **ID/EX update** (when !ex_valid || ex_ready):
  - On fire: load all fields, ex_valid=1.
  - Otherwise: ex_valid=0 (bubble); other fields may hold.
- **ID/EX hold:** when ex_valid && !ex_ready, all ID/EX fields hold and id_ready=0.
- **Branch:** evaluated only on fire with id_is_branch=1, using resolved operands.
  - funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - Other funct3 values: not taken.
- **Branch taken:** br_taken and if_flush are high in that cycle only. The branch itself still enters ID/EX.
- **Stall counter:** stall_cnt increments on every cycle with id_valid && stall. It saturates at all-ones and never wraps.
- **Simultaneous events:** a hazard and a downstream back-pressure in the same cycle count as a hazard stall. A branch is never taken while stalled.
- **Latency:** 1 cycle from fire to ex_valid.

Test Plan:
- FWD_EN=1. ID/EX holds add x5 (ex_valid=1, ex_rd=5, ex_reg_wr_en=1), ID issues sub with rs1=5 -> id_ready=0 for 1 cycle, bubble inserted (ex_valid=0), stall_cnt=1. Next cycle EX/MEM has rd=5 with alu_out=0x1234 -> ex_rs1_data=0x1234.
- FWD_EN=1, no ID/EX writer. EX/MEM rd=3 alu_out=0xA and MEM/WB rd=3 data=0xB, ID rs2=3 -> ex_rs2_data=0xA (EX/MEM wins).
- FWD_EN=0. MEM/WB rd=7 valid, ID rs1=7 -> stall until MEM/WB retires. Operand then comes from rf_rs1_data.
- Branch blt, rs1 operand 0xFFFFFFFF, rs2 operand 1, id_pc=0x100, imm=0x20 -> br_taken=1, if_flush=1, br_target=0x120. Same operands with bltu -> br_taken=0.
- ex_ready=0 for 3 cycles with ex_valid=1 -> ID/EX fields stable, id_ready=0, stall_cnt unchanged.
- Rs1=0 with ID/EX rd=0 writer -> no stall, operand 0. Assert reset_n=0 mid-stall -> ex_valid=0, stall_cnt=0 next edge.
